// File: rtl/irq_pkg.sv
// Shared constants and types for the platform interrupt controller.
// Register word addresses, the gateway state encoding and the id limits.
package irq_pkg;

    localparam int NUM_SRC_MAX = 31;
    localparam int IRQ_ID_W    = 5;

    localparam logic [5:0] IRQ_ADDR_ENABLE    = 6'h00;
    localparam logic [5:0] IRQ_ADDR_THRESH    = 6'h01;
    localparam logic [5:0] IRQ_ADDR_CLAIM     = 6'h02;
    localparam logic [5:0] IRQ_ADDR_PRIO_BASE = 6'h04;

    typedef enum logic [1:0] {
        GW_IDLE      = 2'd0,
        GW_PENDING   = 2'd1,
        GW_INSERVICE = 2'd2
    } gw_state_e;

endpackage

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: IDLE -> PENDING -> INSERVICE -> IDLE.
// With IRQ_EDGE_EN defined, requests are rising edges with a 1-deep memory while INSERVICE.
module irq_gateway
    import irq_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      src_i,
    input  logic      claim_i,
    input  logic      complete_i,
    output logic      pending_o,
    output gw_state_e state_o
);

    gw_state_e state_q;
    logic      pending_q;
    logic      req;

`ifdef IRQ_EDGE_EN
    logic prev_q;
    logic mem_q;
    assign req = src_i & ~prev_q;
`else
    assign req = src_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= GW_IDLE;
            pending_q <= 1'b0;
`ifdef IRQ_EDGE_EN
            prev_q    <= 1'b0;
            mem_q     <= 1'b0;
`endif
        end else begin
`ifdef IRQ_EDGE_EN
            prev_q <= src_i;
`endif
            case (state_q)
                GW_IDLE: begin
                    if (req) begin
                        state_q   <= GW_PENDING;
                        pending_q <= 1'b1;
                    end
                end
                GW_PENDING: begin
                    // Further requests while pending merge into this one.
                    if (claim_i) begin
                        state_q   <= GW_INSERVICE;
                        pending_q <= 1'b0;
                    end
                end
                GW_INSERVICE: begin
`ifdef IRQ_EDGE_EN
                    if (complete_i) begin
                        mem_q <= 1'b0;
                        if (mem_q || req) begin
                            state_q   <= GW_PENDING;
                            pending_q <= 1'b1;
                        end else begin
                            state_q <= GW_IDLE;
                        end
                    end else if (req) begin
                        mem_q <= 1'b1;
                    end
`else
                    if (complete_i) begin
                        state_q <= GW_IDLE;
                    end
`endif
                end
                default: begin
                    state_q   <= GW_IDLE;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign pending_o = pending_q;
    assign state_o   = state_q;

endmodule

// File: rtl/irq_ctrl.sv
// Platform interrupt controller: gateways, priority arbitration, claim/complete register port.
// Build option IRQ_EDGE_EN selects edge-triggered gateways (default: level-sensitive).
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               reg_req,
    input  logic               reg_we,
    input  logic [5:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               reg_rvalid,
    output logic               ext_irq
);

    logic [NUM_SRC-1:0]  enable_q;
    logic [PRIO_W-1:0]   thresh_q;
    logic [PRIO_W-1:0]   prio_q [NUM_SRC];
    logic [31:0]         rdata_d;
    logic [31:0]         rdata_q;
    logic                rvalid_q;
    logic                ext_irq_d;
    logic                ext_irq_q;

    logic [NUM_SRC-1:0]  pending;
    logic [NUM_SRC-1:0]  claim_vec;
    logic [NUM_SRC-1:0]  complete_vec;
    gw_state_e           gw_state [NUM_SRC];

    logic [IRQ_ID_W-1:0] best_id;
    logic [PRIO_W-1:0]   best_prio;
    logic                rd_en;
    logic                wr_en;
    logic                claim_rd;
    logic                complete_wr;
    logic                unused_wdata;

    assign rd_en       = reg_req & ~reg_we;
    assign wr_en       = reg_req & reg_we;
    assign claim_rd    = rd_en && (reg_addr == IRQ_ADDR_CLAIM);
    assign complete_wr = wr_en && (reg_addr == IRQ_ADDR_CLAIM);
    assign unused_wdata = ^reg_wdata;

    // Strict '>' while scanning upward from id 1 leaves ties with the lowest id.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && enable_q[i] && (prio_q[i] > thresh_q) && (prio_q[i] > best_prio)) begin
                best_prio = prio_q[i];
                best_id   = IRQ_ID_W'(i + 1);
            end
        end
    end

    assign ext_irq_d = (best_id != '0);

    always_comb begin
        claim_vec    = '0;
        complete_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_vec[i]    = claim_rd && (best_id == IRQ_ID_W'(i + 1));
            complete_vec[i] = complete_wr && (reg_wdata[IRQ_ID_W-1:0] == IRQ_ID_W'(i + 1))
                              && (gw_state[i] == GW_INSERVICE);
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        irq_gateway u_gw (
            .clk        (clk),
            .rst        (rst),
            .src_i      (src_irq[g]),
            .claim_i    (claim_vec[g]),
            .complete_i (complete_vec[g]),
            .pending_o  (pending[g]),
            .state_o    (gw_state[g])
        );
    end

    always_comb begin
        rdata_d = '0;
        if (reg_addr == IRQ_ADDR_ENABLE) begin
            rdata_d[NUM_SRC:1] = enable_q;
        end else if (reg_addr == IRQ_ADDR_THRESH) begin
            rdata_d[PRIO_W-1:0] = thresh_q;
        end else if (reg_addr == IRQ_ADDR_CLAIM) begin
            rdata_d[IRQ_ID_W-1:0] = best_id;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (reg_addr == IRQ_ADDR_PRIO_BASE + 6'(i)) begin
                    rdata_d[PRIO_W-1:0] = prio_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q  <= '0;
            thresh_q  <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                prio_q[i] <= '0;
            end
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            ext_irq_q <= 1'b0;
        end else begin
            rvalid_q  <= rd_en;
            ext_irq_q <= ext_irq_d;
            if (rd_en) begin
                rdata_q <= rdata_d;
            end
            if (wr_en) begin
                if (reg_addr == IRQ_ADDR_ENABLE) begin
                    enable_q <= reg_wdata[NUM_SRC:1];
                end
                if (reg_addr == IRQ_ADDR_THRESH) begin
                    thresh_q <= reg_wdata[PRIO_W-1:0];
                end
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (reg_addr == IRQ_ADDR_PRIO_BASE + 6'(i)) begin
                        prio_q[i] <= reg_wdata[PRIO_W-1:0];
                    end
                end
            end
        end
    end

    assign reg_rdata  = rdata_q;
    assign reg_rvalid = rvalid_q;
    assign ext_irq    = ext_irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic against a reference model.
// Expected read data and per-cycle ext_irq/rvalid are queued by the driver and popped by a monitor.
module tb_irq_ctrl;

    localparam int N  = 4;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  src_irq;
    logic          reg_req;
    logic          reg_we;
    logic [5:0]    reg_addr;
    logic [31:0]   reg_wdata;
    logic [31:0]   reg_rdata;
    logic          reg_rvalid;
    logic          ext_irq;

    irq_ctrl #(.NUM_SRC(N), .PRIO_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_irq    (src_irq),
        .reg_req    (reg_req),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .ext_irq    (ext_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [1:0]  exp_cyc_q[$];
    logic [N-1:0] src_cur;

    // Reference model: separate flags per id (index 0 unused).
    bit m_pend [0:N];
    bit m_insv [0:N];
    bit m_mem  [0:N];
    bit m_prev [0:N];
    bit m_en   [0:N];
    int m_prio [0:N];
    int m_thr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int id = 0; id <= N; id++) begin
            m_pend[id] = 0; m_insv[id] = 0; m_mem[id] = 0; m_prev[id] = 0;
            m_en[id] = 0; m_prio[id] = 0;
        end
        m_thr = 0;
    endtask

    function automatic bit is_cand(int id);
        return m_pend[id] && m_en[id] && (m_prio[id] > m_thr);
    endfunction

    // Find the top priority among candidates, then the lowest id holding it.
    function automatic int model_best();
        int top;
        top = 0;
        for (int id = 1; id <= N; id++)
            if (is_cand(id) && m_prio[id] > top) top = m_prio[id];
        if (top == 0) return 0;
        for (int id = 1; id <= N; id++)
            if (is_cand(id) && m_prio[id] == top) return id;
        return 0;
    endfunction

    function automatic logic [31:0] model_read(int addr, int best);
        logic [31:0] v;
        v = '0;
        if (addr == 0) begin
            for (int id = 1; id <= N; id++) v[id] = m_en[id];
        end else if (addr == 1) begin
            v = m_thr;
        end else if (addr == 2) begin
            v = best;
        end else if (addr >= 4 && addr < 4 + N) begin
            v = m_prio[addr - 3];
        end
        return v;
    endfunction

    task automatic model_step(input bit req, input bit we, input int addr,
                              input logic [31:0] wdata, input logic [N-1:0] src);
        int best, claim_id, cid;
        bit rq;
        best = model_best();
        exp_cyc_q.push_back({req && !we, best != 0});
        if (req && !we) exp_q.push_back(model_read(addr, best));
        claim_id = (req && !we && addr == 2) ? best : 0;
        cid      = (req && we && addr == 2) ? int'(wdata[4:0]) : 0;
        for (int id = 1; id <= N; id++) begin
`ifdef IRQ_EDGE_EN
            rq = src[id-1] && !m_prev[id];
`else
            rq = src[id-1];
`endif
            if (m_insv[id]) begin
                if (cid == id) begin
                    m_insv[id] = 0;
`ifdef IRQ_EDGE_EN
                    m_pend[id] = m_mem[id] || rq;
                    m_mem[id]  = 0;
`endif
                end else if (rq) begin
`ifdef IRQ_EDGE_EN
                    m_mem[id] = 1;
`endif
                end
            end else if (m_pend[id]) begin
                if (claim_id == id) begin
                    m_pend[id] = 0;
                    m_insv[id] = 1;
                end
            end else if (rq) begin
                m_pend[id] = 1;
            end
            m_prev[id] = src[id-1];
        end
        if (req && we) begin
            if (addr == 0) for (int id = 1; id <= N; id++) m_en[id] = wdata[id];
            if (addr == 1) m_thr = int'(wdata[PW-1:0]);
            if (addr >= 4 && addr < 4 + N) m_prio[addr - 3] = int'(wdata[PW-1:0]);
        end
    endtask

    task automatic cyc(input bit req, input bit we, input logic [5:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        reg_req   = req;
        reg_we    = we;
        reg_addr  = addr;
        reg_wdata = wdata;
        src_irq   = src_cur;
        model_step(req, we, int'(addr), wdata, src_cur);
    endtask

    task automatic rd(input logic [5:0] addr);
        cyc(1'b1, 1'b0, addr, 32'h0);
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data);
        cyc(1'b1, 1'b1, addr, data);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 6'h0, 32'h0);
    endtask

    // Monitor: one expectation per driven cycle, checked 1 time unit after the edge.
    initial begin : monitor
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_cyc_q.size() > 0) begin
                e = exp_cyc_q.pop_front();
                check("ext_irq", ext_irq, e[0]);
                check("rvalid", reg_rvalid, e[1]);
                if (e[1] && reg_rvalid) begin
                    if (exp_q.size() > 0) check("rdata", reg_rdata, exp_q.pop_front());
                    else check("rdata_queue", 32'(exp_q.size()), 32'd1);
                end
            end else if (!rst) begin
                check("idle_rvalid", reg_rvalid, 1'b0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; reg_req = 0; reg_we = 0; reg_addr = '0; reg_wdata = '0;
        src_cur = '0; src_irq = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ext_irq", ext_irq, 1'b0);
        check("reset_rvalid", reg_rvalid, 1'b0);
        check("reset_rdata", reg_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        rd(6'h00); rd(6'h01); rd(6'h04); rd(6'h02);

        // Single source, claim, complete.
        wr(6'h04, 32'd2); wr(6'h00, 32'h2);
        src_cur = 4'b0001; idle(3); rd(6'h02); idle(2);
        src_cur = 4'b0000; wr(6'h02, 32'd1); idle(1);

        // Equal priorities resolve to the lowest id.
        wr(6'h04, 32'd3); wr(6'h05, 32'd3); wr(6'h00, 32'h6);
        src_cur = 4'b0011; idle(2); rd(6'h02); rd(6'h02); rd(6'h02);
        src_cur = 4'b0000; wr(6'h02, 32'd1); wr(6'h02, 32'd2); idle(2);

        // Threshold masks, then unmasks.
        wr(6'h01, 32'd3); src_cur = 4'b0010; idle(3);
        wr(6'h01, 32'd2); idle(2); rd(6'h02);
        src_cur = 4'b0000; wr(6'h02, 32'd2); wr(6'h01, 32'd0); idle(1);

        // Complete while source held high; complete of an idle id.
        src_cur = 4'b0001; idle(2); rd(6'h02); idle(1);
        wr(6'h02, 32'd1); idle(3); wr(6'h02, 32'd3); rd(6'h02); idle(1);
        src_cur = 4'b0000; wr(6'h02, 32'd1); idle(2);

`ifdef IRQ_EDGE_EN
        // Edge memory while in service, and merging while pending.
        src_cur = 4'b0010; idle(1); src_cur = 4'b0000; idle(2); rd(6'h02);
        src_cur = 4'b0010; idle(1); src_cur = 4'b0000; idle(1);
        wr(6'h02, 32'd2); idle(2); rd(6'h02); wr(6'h02, 32'd2); idle(1);
        src_cur = 4'b0010; idle(1); src_cur = 4'b0000; idle(1);
        src_cur = 4'b0010; idle(1); src_cur = 4'b0000; idle(1);
        rd(6'h02); rd(6'h02); wr(6'h02, 32'd2); idle(2);
`endif

        // Reset with id 1 in service, id 2 pending and a read in flight.
        wr(6'h00, 32'h6); wr(6'h04, 32'd2); wr(6'h05, 32'd1);
        src_cur = 4'b0001; idle(2); rd(6'h02);
        src_cur = 4'b0011; idle(3); rd(6'h00);
        @(posedge clk);
        #3;
        rst = 1'b1; reg_req = 0; reg_we = 0; src_cur = '0; src_irq = '0;
        #1;
        check("midreset_rvalid", reg_rvalid, 1'b0);
        check("midreset_ext_irq", ext_irq, 1'b0);
        exp_q.delete(); exp_cyc_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(6'h02); src_cur = 4'b0001; idle(3); rd(6'h02);
        wr(6'h00, 32'h2); wr(6'h04, 32'd2); idle(2); rd(6'h02);
        src_cur = 4'b0000; wr(6'h02, 32'd1); idle(2);

        // Random traffic.
        wr(6'h00, 32'h1E);
        for (int id = 0; id < N; id++) wr(6'h04 + 6'(id), 32'($urandom_range(0, 7)));
        for (int k = 0; k < 1500; k++) begin
            int op;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) src_cur[b] = ~src_cur[b];
            op = $urandom_range(0, 15);
            if (op <= 4) idle(1);
            else if (op <= 8) rd(6'h02);
            else if (op <= 10) wr(6'h02, 32'($urandom_range(0, 7)));
            else if (op == 11) wr(6'h00, $urandom);
            else if (op == 12) wr(6'h01, 32'($urandom_range(0, 4)));
            else if (op == 13) wr(6'h04 + 6'($urandom_range(0, N)), 32'($urandom_range(0, 7)));
            else if (op == 14) rd(6'($urandom_range(0, 63)));
            else wr(6'($urandom_range(0, 63)), $urandom);
        end

        idle(3);
        @(posedge clk);
        #2;
        check("drain_cycle_queue", 32'(exp_cyc_q.size()), 32'd0);
        check("drain_read_queue", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
